// File: rtl/fir_host_pkg.sv
// Shared types and sizes for the FIR core host driver.
package fir_host_pkg;

  localparam int NUM_COEFF = 4;
  localparam int WORD_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_C_REQ   = 3'd1,
    ST_C_DONE  = 3'd2,
    ST_S_REQ   = 3'd3,
    ST_S_DONE  = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_FAULT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE         = 2'd0,
    FC_ACK_TIMEOUT  = 2'd1,
    FC_DONE_TIMEOUT = 2'd2,
    FC_CORE_ERR     = 2'd3
  } fault_code_e;

endpackage

// File: rtl/fir_host_driver_fifo.sv
// Synchronous sample FIFO; head is read straight from the storage registers.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A pop on an empty FIFO is a no-op; a push into a full FIFO only lands if a pop frees a slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/fir_host_driver.sv
// Host-side initiator for the FIR core: sequences coefficient loads and samples through the
// load_coeff/data_ready/modwait handshake and captures each filtered result.
module fir_host_driver
  import fir_host_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int ACK_TIMEOUT  = 16,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] coeff_in,
  input  logic              coeff_wr,
  input  logic [1:0]        coeff_idx,
  input  logic              coeff_go,
  input  logic [WORD_W-1:0] sample_in,
  input  logic              sample_wr,
  output logic              sample_full,
  output logic              sample_empty,
  output logic              sample_ovf,
  input  logic              fir_modwait,
  input  logic [WORD_W-1:0] fir_result,
  input  logic              fir_err,
  output logic [WORD_W-1:0] fir_sample_data,
  output logic [WORD_W-1:0] fir_coefficient,
  output logic              fir_data_ready,
  output logic              fir_load_coeff,
  output logic [WORD_W-1:0] result,
  output logic              result_valid,
  output logic              coeff_busy,
  output logic              fault,
  output logic [1:0]        fault_code,
  input  logic              clear_fault,
  output logic [2:0]        dbg_state_o
);

  // Handshake: the driver raises one strobe (load_coeff or data_ready) with its data held stable;
  // the core acknowledges by raising modwait, the strobe drops on that edge, and the transaction
  // completes when modwait falls. At most one transaction is outstanding at any time.

  localparam int TMAX = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] DONE_LAST = TW'(DONE_TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);

  state_e            state_q;
  fault_code_e       fault_code_q;
  logic [TW-1:0]     timer_q;
  logic [1:0]        k_q;
  logic [WORD_W-1:0] coeff_q [NUM_COEFF];
  logic [WORD_W-1:0] coef_out_q, samp_out_q, result_q;
  logic              load_q, ready_q, result_valid_q, coeff_busy_q;
  logic              retry_q, fault_q, ovf_q;

  logic [WORD_W-1:0] fifo_head;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic              in_req, in_done, ack_to, done_to, fault_hit;

  sample_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (sample_wr),
    .pop_i   (fifo_pop),
    .data_i  (sample_in),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_req    = (state_q == ST_C_REQ) || (state_q == ST_S_REQ);
  assign in_done   = (state_q == ST_C_DONE) || (state_q == ST_S_DONE);
  assign ack_to    = in_req && !fir_modwait && (timer_q == ACK_LAST);
  assign done_to   = in_done && fir_modwait && (timer_q == DONE_LAST);
  assign fault_hit = (state_q != ST_IDLE) && (state_q != ST_FAULT) &&
                     (fir_err || ack_to || done_to);
  // retry_q holds a popped sample whose request was never acknowledged; it is resent before the FIFO.
  assign fifo_pop  = (state_q == ST_IDLE) && !fir_modwait && !clear_fault &&
                     !coeff_busy_q && !retry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      fault_code_q   <= FC_NONE;
      timer_q        <= '0;
      k_q            <= '0;
      for (int i = 0; i < NUM_COEFF; i++) coeff_q[i] <= '0;
      coef_out_q     <= '0;
      samp_out_q     <= '0;
      result_q       <= '0;
      load_q         <= 1'b0;
      ready_q        <= 1'b0;
      result_valid_q <= 1'b0;
      coeff_busy_q   <= 1'b0;
      retry_q        <= 1'b0;
      fault_q        <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (coeff_wr && !coeff_busy_q) coeff_q[coeff_idx] <= coeff_in;
      if (coeff_go && !coeff_busy_q && !fault_q) coeff_busy_q <= 1'b1;
      if (sample_wr && fifo_full && !fifo_pop) ovf_q <= 1'b1;

      if (clear_fault) begin
        state_q      <= ST_IDLE;
        fault_q      <= 1'b0;
        fault_code_q <= FC_NONE;
        ovf_q        <= 1'b0;
        load_q       <= 1'b0;
        ready_q      <= 1'b0;
        timer_q      <= '0;
      end else if (fault_hit) begin
        state_q      <= ST_FAULT;
        fault_q      <= 1'b1;
        fault_code_q <= fir_err ? FC_CORE_ERR : (ack_to ? FC_ACK_TIMEOUT : FC_DONE_TIMEOUT);
        load_q       <= 1'b0;
        ready_q      <= 1'b0;
        timer_q      <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            timer_q <= '0;
            if (!fir_modwait) begin
              if (coeff_busy_q) begin
                state_q    <= ST_C_REQ;
                k_q        <= 2'd0;
                load_q     <= 1'b1;
                coef_out_q <= coeff_q[0];
              end else if (retry_q) begin
                state_q <= ST_S_REQ;
                ready_q <= 1'b1;
              end else if (!fifo_empty) begin
                state_q    <= ST_S_REQ;
                ready_q    <= 1'b1;
                samp_out_q <= fifo_head;
                retry_q    <= 1'b1;
              end
            end
          end
          ST_C_REQ: begin
            if (fir_modwait) begin
              state_q <= ST_C_DONE;
              load_q  <= 1'b0;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + T_ONE;
            end
          end
          ST_C_DONE: begin
            if (!fir_modwait) begin
              timer_q <= '0;
              if (k_q == 2'd3) begin
                state_q      <= ST_IDLE;
                coeff_busy_q <= 1'b0;
              end else begin
                state_q    <= ST_C_REQ;
                k_q        <= k_q + 2'd1;
                load_q     <= 1'b1;
                coef_out_q <= coeff_q[k_q + 2'd1];
              end
            end else begin
              timer_q <= timer_q + T_ONE;
            end
          end
          ST_S_REQ: begin
            if (fir_modwait) begin
              state_q <= ST_S_DONE;
              ready_q <= 1'b0;
              retry_q <= 1'b0;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + T_ONE;
            end
          end
          ST_S_DONE: begin
            if (!fir_modwait) begin
              state_q <= ST_CAPTURE;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + T_ONE;
            end
          end
          ST_CAPTURE: begin
            result_q       <= fir_result;
            result_valid_q <= 1'b1;
            state_q        <= ST_IDLE;
            timer_q        <= '0;
          end
          ST_FAULT: timer_q <= '0;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign sample_full     = fifo_full;
  assign sample_empty    = fifo_empty;
  assign sample_ovf      = ovf_q;
  assign fir_sample_data = samp_out_q;
  assign fir_coefficient = coef_out_q;
  assign fir_data_ready  = ready_q;
  assign fir_load_coeff  = load_q;
  assign result          = result_q;
  assign result_valid    = result_valid_q;
  assign coeff_busy      = coeff_busy_q;
  assign fault           = fault_q;
  assign fault_code      = fault_code_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_fir_host_driver.sv
// Directed bench for fir_host_driver with a behavioural 4-tap FIR core on the far side.
module tb_fir_host_driver;
  import fir_host_pkg::*;

  logic        clk, rst;
  logic [15:0] coeff_in, sample_in, fir_result, fir_sample_data, fir_coefficient, result;
  logic        coeff_wr, coeff_go, sample_wr, clear_fault, fir_err;
  logic [1:0]  coeff_idx, fault_code;
  logic        sample_full, sample_empty, sample_ovf, fir_modwait;
  logic        fir_data_ready, fir_load_coeff, result_valid, coeff_busy, fault;
  logic [2:0]  dbg_state;

  logic        core_busy, core_stall, core_alive;
  assign fir_modwait = core_busy || core_stall;

  int          total, bad;
  logic [16:0] ev_q[$];   // {is_sample, value} per strobe rising edge
  logic [15:0] res_q[$];
  logic [15:0] exp_q[$];
  logic        prev_lc, prev_dr;

  fir_host_driver #(.DEPTH(8), .ACK_TIMEOUT(16), .DONE_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .coeff_in(coeff_in), .coeff_wr(coeff_wr), .coeff_idx(coeff_idx),
    .coeff_go(coeff_go), .sample_in(sample_in), .sample_wr(sample_wr),
    .sample_full(sample_full), .sample_empty(sample_empty), .sample_ovf(sample_ovf),
    .fir_modwait(fir_modwait), .fir_result(fir_result), .fir_err(fir_err),
    .fir_sample_data(fir_sample_data), .fir_coefficient(fir_coefficient),
    .fir_data_ready(fir_data_ready), .fir_load_coeff(fir_load_coeff), .result(result),
    .result_valid(result_valid), .coeff_busy(coeff_busy), .fault(fault),
    .fault_code(fault_code), .clear_fault(clear_fault), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- core model: ack after 3 cycles, busy for 3, y = sum f[i]*x[n-i] ----------------
  initial begin : core_model
    logic [15:0] mcoef [4];
    logic [15:0] hist [4];
    logic [1:0]  cidx;
    logic [31:0] acc;
    logic        is_samp;
    core_busy = 1'b0;
    fir_result = '0;
    cidx = '0;
    acc = '0;
    for (int i = 0; i < 4; i++) begin mcoef[i] = '0; hist[i] = '0; end
    forever begin
      @(negedge clk);
      if (rst) begin
        core_busy = 1'b0;
        fir_result = '0;
        cidx = '0;
        for (int i = 0; i < 4; i++) begin mcoef[i] = '0; hist[i] = '0; end
      end else if (core_alive && (fir_load_coeff || fir_data_ready)) begin
        is_samp = fir_data_ready;
        if (!is_samp) begin
          mcoef[cidx] = fir_coefficient;
          cidx = cidx + 2'd1;
        end else begin
          for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
          hist[0] = fir_sample_data;
          acc = '0;
          for (int i = 0; i < 4; i++) acc = acc + 32'(mcoef[i]) * 32'(hist[i]);
        end
        repeat (2) @(negedge clk);
        core_busy = 1'b1;
        repeat (3) @(negedge clk);
        if (is_samp) fir_result = acc[15:0];
        core_busy = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      ev_q.delete();
      res_q.delete();
      prev_lc = 1'b0;
      prev_dr = 1'b0;
    end else begin
      if (fir_load_coeff && !prev_lc) ev_q.push_back({1'b0, fir_coefficient});
      if (fir_data_ready && !prev_dr) ev_q.push_back({1'b1, fir_sample_data});
      if (result_valid) res_q.push_back(result);
      prev_lc = fir_load_coeff;
      prev_dr = fir_data_ready;
    end
  end

  // ---------------- driver tasks (all entered and left at a falling edge) ----------------
  task automatic do_reset();
    rst = 1'b1;
    coeff_in = '0; coeff_wr = 1'b0; coeff_idx = '0; coeff_go = 1'b0;
    sample_in = '0; sample_wr = 1'b0; clear_fault = 1'b0; fir_err = 1'b0;
    core_alive = 1'b1; core_stall = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_coeff(input logic [1:0] idx, input logic [15:0] v);
    coeff_idx = idx; coeff_in = v; coeff_wr = 1'b1;
    @(negedge clk);
    coeff_wr = 1'b0;
  endtask

  task automatic pulse_go();
    coeff_go = 1'b1;
    @(negedge clk);
    coeff_go = 1'b0;
  endtask

  task automatic push_sample(input logic [15:0] v);
    sample_in = v; sample_wr = 1'b1;
    @(negedge clk);
    sample_wr = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (res_q.size() < n && c < budget) begin @(negedge clk); c++; end
    ok = (res_q.size() >= n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++; if ({fir_load_coeff, fir_data_ready, result_valid, coeff_busy, fault, sample_full, sample_ovf} !== 7'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000000", {fir_load_coeff, fir_data_ready, result_valid, coeff_busy, fault, sample_full, sample_ovf}); end
    total++; if (sample_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", sample_empty); end
    total++; if ({fir_sample_data, fir_coefficient, result} !== 48'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {fir_sample_data, fir_coefficient, result}); end
    total++; if (fault_code !== 2'd0) begin bad++; $display("FAIL reset_code: got %0d want 0", fault_code); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if ({fir_load_coeff, fir_data_ready} !== 2'b00) begin
        bad++; $display("FAIL idle_strobes: cycle %0d got %b want 00", i, {fir_load_coeff, fir_data_ready}); end
    end
    // reset in the middle of a sample request
    core_alive = 1'b0;
    push_sample(16'h1234);
    repeat (2) @(negedge clk);
    total++; if ({fir_data_ready, fir_sample_data} !== {1'b1, 16'h1234}) begin
      bad++; $display("FAIL midtx_req: got %b/%h want 1/1234", fir_data_ready, fir_sample_data); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({fir_data_ready, sample_empty, fir_sample_data} !== {1'b0, 1'b1, 16'h0}) begin
      bad++; $display("FAIL midtx_abort: got %b/%b/%h want 0/1/0000", fir_data_ready, sample_empty, fir_sample_data); end
  endtask

  task automatic test_coeff_load();
    logic [15:0] cv [4];
    int n;
    cv = '{16'd1, 16'd2, 16'd3, 16'd4};
    do_reset();
    for (int i = 0; i < 4; i++) write_coeff(2'(i), cv[i]);
    pulse_go();
    total++; if (coeff_busy !== 1'b1) begin bad++; $display("FAIL coeff_busy_set: got %b want 1", coeff_busy); end
    n = 0;
    while (coeff_busy && n < 300) begin @(negedge clk); n++; end
    total++; if (coeff_busy !== 1'b0) begin bad++; $display("FAIL coeff_busy_drop: got %b want 0 (timeout)", coeff_busy); end
    total++; if (ev_q.size() != 4) begin bad++; $display("FAIL coeff_count: got %0d want 4", ev_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (ev_q[i] !== {1'b0, cv[i]}) begin bad++; $display("FAIL coeff_order[%0d]: got %h want %h", i, ev_q[i], {1'b0, cv[i]}); end
    end
  endtask

  task automatic test_samples();
    bit ok;
    logic [15:0] sv [3];
    logic [15:0] want;
    sv = '{16'h0010, 16'h0020, 16'h0030};
    exp_q = '{16'h0010, 16'h0040, 16'h00A0};
    for (int i = 0; i < 3; i++) push_sample(sv[i]);
    wait_results(3, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL samp_wait: got %0d results want 3 (timeout)", res_q.size()); end
    repeat (5) @(negedge clk);
    total++; if (res_q.size() != 3) begin bad++; $display("FAIL samp_pulses: got %0d want 3", res_q.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (ev_q[4+i] !== {1'b1, sv[i]}) begin bad++; $display("FAIL samp_order[%0d]: got %h want %h", i, ev_q[4+i], {1'b1, sv[i]}); end
      want = exp_q.pop_front();
      total++; if (res_q[i] !== want) begin bad++; $display("FAIL samp_result[%0d]: got %h want %h", i, res_q[i], want); end
    end
    total++; if (sample_empty !== 1'b1) begin bad++; $display("FAIL samp_drained: got %b want 1", sample_empty); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [16:0] ev_exp [5];
    ev_exp = '{17'h00002, 17'h00001, 17'h00000, 17'h00000, 17'h10100};
    do_reset();
    write_coeff(2'd0, 16'd2);
    write_coeff(2'd1, 16'd1);
    coeff_go = 1'b1; sample_in = 16'h0100; sample_wr = 1'b1;
    @(negedge clk);
    coeff_go = 1'b0; sample_wr = 1'b0;
    wait_results(1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_wait: got %0d results want 1 (timeout)", res_q.size()); end
    total++; if (ev_q.size() != 5) begin bad++; $display("FAIL b2b_count: got %0d want 5", ev_q.size()); end
    for (int i = 0; i < 5; i++) begin
      total++; if (ev_q[i] !== ev_exp[i]) begin bad++; $display("FAIL b2b_order[%0d]: got %h want %h", i, ev_q[i], ev_exp[i]); end
    end
    total++; if (res_q[0] !== 16'h0200) begin bad++; $display("FAIL b2b_result: got %h want 0200", res_q[0]); end
  endtask

  task automatic test_ack_timeout();
    bit ok;
    int n, cnt;
    do_reset();
    write_coeff(2'd0, 16'd1);
    pulse_go();
    n = 0;
    while (coeff_busy && n < 300) begin @(negedge clk); n++; end
    core_alive = 1'b0;
    push_sample(16'h0055);
    n = 0;
    while (!fir_data_ready && n < 20) begin @(negedge clk); n++; end
    total++; if (fir_data_ready !== 1'b1) begin bad++; $display("FAIL to_req: got %b want 1 (timeout)", fir_data_ready); end
    cnt = 0;
    while (!fault && cnt < 100) begin @(negedge clk); cnt++; end
    total++; if (cnt != 16) begin bad++; $display("FAIL to_cycles: got %0d want 16", cnt); end
    total++; if ({fault, fault_code, fir_data_ready} !== {1'b1, 2'd1, 1'b0}) begin
      bad++; $display("FAIL to_fault: got %b/%0d/%b want 1/1/0", fault, fault_code, fir_data_ready); end
    core_alive = 1'b1;
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    total++; if ({fault, fault_code} !== 3'b000) begin bad++; $display("FAIL to_clear: got %b/%0d want 0/0", fault, fault_code); end
    wait_results(1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_retry_wait: got %0d results want 1 (timeout)", res_q.size()); end
    total++; if (ev_q.size() != 6 || ev_q[5] !== 17'h10055) begin
      bad++; $display("FAIL to_retry_sent: got %0d events last %h want 6 last 10055", ev_q.size(), ev_q[ev_q.size()-1]); end
    total++; if (res_q[0] !== 16'h0055) begin bad++; $display("FAIL to_retry_result: got %h want 0055", res_q[0]); end
  endtask

  task automatic test_overflow_err();
    bit ok;
    int n, hits;
    do_reset();
    core_stall = 1'b1;
    write_coeff(2'd0, 16'd1);
    pulse_go();
    for (int i = 1; i <= 8; i++) push_sample(16'(i));
    total++; if ({sample_full, sample_ovf} !== 2'b10) begin bad++; $display("FAIL ovf_fill: got %b want 10", {sample_full, sample_ovf}); end
    push_sample(16'h0999);
    total++; if ({sample_full, sample_ovf} !== 2'b11) begin bad++; $display("FAIL ovf_set: got %b want 11", {sample_full, sample_ovf}); end
    core_stall = 1'b0;
    wait_results(8, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_drain: got %0d results want 8 (timeout)", res_q.size()); end
    repeat (10) @(negedge clk);
    hits = 0;
    foreach (ev_q[i]) if (ev_q[i] === 17'h10999) hits++;
    total++; if (hits != 0 || ev_q.size() != 12) begin bad++; $display("FAIL ovf_dropped: got %0d events, %0d of 0999 want 12, 0", ev_q.size(), hits); end
    total++; if (res_q[0] !== 16'h0001 || res_q[7] !== 16'h0008) begin
      bad++; $display("FAIL ovf_results: got %h..%h want 0001..0008", res_q[0], res_q[7]); end
    total++; if ({sample_empty, sample_ovf} !== 2'b11) begin bad++; $display("FAIL ovf_sticky: got %b want 11", {sample_empty, sample_ovf}); end
    // core error while a sample request is outstanding
    core_alive = 1'b0;
    push_sample(16'h0042);
    n = 0;
    while (!fir_data_ready && n < 20) begin @(negedge clk); n++; end
    fir_err = 1'b1;
    @(negedge clk);
    fir_err = 1'b0;
    total++; if ({fault, fault_code, fir_data_ready} !== {1'b1, 2'd3, 1'b0}) begin
      bad++; $display("FAIL err_fault: got %b/%0d/%b want 1/3/0", fault, fault_code, fir_data_ready); end
    repeat (20) @(negedge clk);
    total++; if (fault_code !== 2'd3) begin bad++; $display("FAIL err_first_wins: got %0d want 3", fault_code); end
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    total++; if ({fault, fault_code, sample_ovf} !== 4'b0000) begin
      bad++; $display("FAIL err_clear: got %b/%0d/%b want 0/0/0", fault, fault_code, sample_ovf); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    core_alive = 1'b1;
    core_stall = 1'b0;
    fir_err = 1'b0;
    test_reset();
    test_coeff_load();
    test_samples();
    test_back_to_back();
    test_ack_timeout();
    test_overflow_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
